// File: rtl/cpu_sdr_bridge.sv
// rtl/cpu_sdr_bridge.sv - V30 bus to toggle-handshake SDRAM bridge with posted-write FIFO
module cpu_sdr_bridge #(
    parameter int ADDR_W      = 20,
    parameter int SDR_ADDR_W  = 25,
    parameter int WBUF_DEPTH  = 4,
    parameter int POST_WRITES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bus_read,
    input  logic                  bus_write,
    input  logic [ADDR_W-1:0]     bus_addr,
    input  logic [1:0]            bus_be,
    input  logic [15:0]           bus_dout,
    input  logic                  region_hit,
    input  logic [SDR_ADDR_W-1:0] region_addr,
    input  logic                  region_writable,
    output logic [15:0]           rd_data,
    output logic                  stall,
    output logic [SDR_ADDR_W-1:0] sdr_addr,
    output logic [15:0]           sdr_din,
    output logic [1:0]            sdr_wr_sel,
    output logic                  sdr_req,
    input  logic                  sdr_ack,
    input  logic [15:0]           sdr_dout,
    output logic [4:0]            wbuf_level
);

    typedef enum logic [1:0] {IDLE, WR_ACT, RD_WAIT, RD_ACT} state_t;

    localparam int   PW     = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam logic POSTED = (POST_WRITES != 0);

    state_t state_q, state_d;

    logic read_d, write_d;
    logic read_edge, write_edge, wr_acc, rd_acc, ack_match;
    logic fifo_empty, fifo_full;
    logic pop, push, issue_wr, issue_rd, wr_from_bus, rd_from_bus;
    logic wr_busy_q;
    logic [SDR_ADDR_W-1:0] rd_addr_q;
    logic rd_odd_q;
    logic [15:0] wr_data_sh;
    logic [1:0]  wr_sel_sh;
    logic unused_addr_bits;

    logic [SDR_ADDR_W-1:0] wbuf_addr [WBUF_DEPTH];
    logic [15:0]           wbuf_data [WBUF_DEPTH];
    logic [1:0]            wbuf_sel  [WBUF_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;

    logic                  skid_valid;
    logic [SDR_ADDR_W-1:0] skid_addr;
    logic [15:0]           skid_data;
    logic [1:0]            skid_sel;
    logic [SDR_ADDR_W-1:0] push_addr;
    logic [15:0]           push_data;
    logic [1:0]            push_sel;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign unused_addr_bits = ^bus_addr[ADDR_W-1:1];

    assign read_edge  = bus_read & ~read_d;
    assign write_edge = bus_write & ~write_d;
    assign wr_acc     = write_edge & region_hit & region_writable;
    // A simultaneous read and write edge is a write; the read is dropped.
    assign rd_acc     = read_edge & region_hit & ~write_edge;
    assign ack_match  = (sdr_ack == sdr_req);
    assign fifo_empty = (wbuf_level == 5'd0);
    assign fifo_full  = (wbuf_level == 5'(WBUF_DEPTH));

    assign wr_data_sh = bus_addr[0] ? {bus_dout[7:0], 8'h00} : bus_dout;
    assign wr_sel_sh  = bus_addr[0] ? {bus_be[0], 1'b0}      : bus_be;

    // A write arriving at a full FIFO waits in the skid register until the next pop frees a slot.
    assign push      = skid_valid ? pop : (POSTED & wr_acc & (~fifo_full | pop));
    assign push_addr = skid_valid ? skid_addr : region_addr;
    assign push_data = skid_valid ? skid_data : wr_data_sh;
    assign push_sel  = skid_valid ? skid_sel  : wr_sel_sh;

    assign stall = rd_acc | (state_q == RD_WAIT) | (state_q == RD_ACT) |
                   (POSTED ? ((wr_acc & fifo_full & ~pop) | skid_valid)
                           : (wr_acc | (state_q == WR_ACT)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue_wr)      state_d = rd_acc ? RD_WAIT : WR_ACT;
                else if (issue_rd) state_d = RD_ACT;
            end
            WR_ACT: begin
                if (rd_acc)         state_d = RD_WAIT;
                else if (ack_match) state_d = IDLE;
            end
            RD_WAIT: if (issue_rd)  state_d = RD_ACT;
            RD_ACT:  if (ack_match) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RD_WAIT keeps draining the FIFO itself; wr_busy_q tracks its in-flight write.
    always_comb begin
        pop         = 1'b0;
        issue_wr    = 1'b0;
        issue_rd    = 1'b0;
        wr_from_bus = 1'b0;
        rd_from_bus = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    issue_wr = 1'b1;
                end else if (!POSTED && wr_acc) begin
                    issue_wr    = 1'b1;
                    wr_from_bus = 1'b1;
                end else if (rd_acc) begin
                    issue_rd    = 1'b1;
                    rd_from_bus = 1'b1;
                end
            end
            RD_WAIT: begin
                if (!wr_busy_q) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        issue_wr = 1'b1;
                    end else begin
                        issue_rd = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wbuf_addr[wr_ptr] <= push_addr;
            wbuf_data[wr_ptr] <= push_data;
            wbuf_sel[wr_ptr]  <= push_sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_d     <= 1'b0;
            write_d    <= 1'b0;
            wr_busy_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_odd_q   <= 1'b0;
            rd_data    <= '0;
            sdr_addr   <= '0;
            sdr_din    <= '0;
            sdr_wr_sel <= '0;
            sdr_req    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wbuf_level <= '0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
            skid_sel   <= '0;
        end else begin
            read_d  <= bus_read;
            write_d <= bus_write;

            if (issue_wr)       wr_busy_q <= 1'b1;
            else if (ack_match) wr_busy_q <= 1'b0;

            if (rd_acc) begin
                rd_addr_q <= region_addr;
                rd_odd_q  <= bus_addr[0];
            end

            if (issue_wr) begin
                sdr_addr   <= wr_from_bus ? region_addr : wbuf_addr[rd_ptr];
                sdr_din    <= wr_from_bus ? wr_data_sh  : wbuf_data[rd_ptr];
                sdr_wr_sel <= wr_from_bus ? wr_sel_sh   : wbuf_sel[rd_ptr];
                sdr_req    <= ~sdr_req;
            end else if (issue_rd) begin
                sdr_addr   <= rd_from_bus ? region_addr : rd_addr_q;
                sdr_wr_sel <= 2'b00;
                sdr_req    <= ~sdr_req;
            end

            if (state_q == RD_ACT && ack_match)
                rd_data <= rd_odd_q ? {8'h00, sdr_dout[15:8]} : sdr_dout;

            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   wbuf_level <= wbuf_level + 5'd1;
                2'b01:   wbuf_level <= wbuf_level - 5'd1;
                default: ;
            endcase

            if (skid_valid) begin
                if (pop) skid_valid <= 1'b0;
            end else if (POSTED && wr_acc && fifo_full && !pop) begin
                skid_valid <= 1'b1;
                skid_addr  <= region_addr;
                skid_data  <= wr_data_sh;
                skid_sel   <= wr_sel_sh;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sdr_bridge.sv
// tb/tb_cpu_sdr_bridge.sv - scoreboard bench for cpu_sdr_bridge with a toggle-handshake SDRAM model
module tb_cpu_sdr_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bus_read = 1'b0, bus_write = 1'b0;
    logic [19:0] bus_addr = '0;
    logic [1:0]  bus_be = '0;
    logic [15:0] bus_dout = '0;
    logic        region_hit = 1'b0, region_writable = 1'b0;
    logic [24:0] region_addr = '0;
    logic [15:0] rd_data, sdr_din, sdr_dout = '0;
    logic        stall, sdr_req, sdr_ack = 1'b0;
    logic [24:0] sdr_addr;
    logic [1:0]  sdr_wr_sel;
    logic [4:0]  wbuf_level;

    cpu_sdr_bridge dut (
        .clk(clk), .reset_n(reset_n),
        .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_dout(bus_dout),
        .region_hit(region_hit), .region_addr(region_addr), .region_writable(region_writable),
        .rd_data(rd_data), .stall(stall),
        .sdr_addr(sdr_addr), .sdr_din(sdr_din), .sdr_wr_sel(sdr_wr_sel),
        .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_dout(sdr_dout),
        .wbuf_level(wbuf_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [24:0] a;
        logic [15:0] d;
        logic [1:0]  s;
    } txn_t;

    txn_t        exp_txn[$];
    logic [15:0] exp_rd[$];
    logic [15:0] ref_mem[int];
    logic [15:0] sdr_mem[int];

    int total = 0, bad = 0;
    int toggles = 0, issued = 0;
    int ack_delay = 1, ack_cnt = 0;
    logic ack_hold = 1'b0, prev_req = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_get(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] sdr_get(input int a);
        return sdr_mem.exists(a) ? sdr_mem[a] : 16'h0000;
    endfunction

    // SDRAM model plus transaction scoreboard, both away from the DUT clock edge.
    always @(negedge clk) begin : sdram
        txn_t t;
        logic [15:0] w;
        if (!reset_n) begin
            sdr_ack  = 1'b0;
            ack_cnt  = 0;
            prev_req = 1'b0;
        end else begin
            if (sdr_req != prev_req) begin
                prev_req = sdr_req;
                toggles++;
                if (exp_txn.size() == 0) begin
                    chk("txn_extra", 32'd1, 32'd0);
                end else begin
                    t = exp_txn.pop_front();
                    chk("txn_addr", 32'(sdr_addr), 32'(t.a));
                    chk("txn_sel", 32'(sdr_wr_sel), 32'(t.s));
                    if (t.wr) chk("txn_din", 32'(sdr_din), 32'(t.d));
                end
            end
            if (sdr_req != sdr_ack && !ack_hold) begin
                if (ack_cnt >= ack_delay) begin
                    w = sdr_get(int'(sdr_addr));
                    if (sdr_wr_sel == 2'b00) begin
                        sdr_dout = w;
                    end else begin
                        if (sdr_wr_sel[1]) w[15:8] = sdr_din[15:8];
                        if (sdr_wr_sel[0]) w[7:0]  = sdr_din[7:0];
                        sdr_mem[int'(sdr_addr)] = w;
                    end
                    sdr_ack = sdr_req;
                    ack_cnt = 0;
                end else begin
                    ack_cnt++;
                end
            end
        end
    end

    task automatic bus_wr(input logic [19:0] a, input logic [1:0] be, input logic [15:0] d,
                          input logic hit, input logic wen, output logic st);
        logic [24:0] ra;
        logic [15:0] dd, w;
        logic [1:0]  ss;
        ra = {6'd0, a[19:1]};
        dd = a[0] ? {d[7:0], 8'h00} : d;
        ss = a[0] ? {be[0], 1'b0} : be;
        @(negedge clk);
        bus_write = 1'b1; bus_addr = a; bus_be = be; bus_dout = d;
        region_hit = hit; region_writable = wen; region_addr = ra;
        if (hit && wen) begin
            exp_txn.push_back('{wr: 1'b1, a: ra, d: dd, s: ss});
            issued++;
            w = ref_get(int'(ra));
            if (ss[1]) w[15:8] = dd[15:8];
            if (ss[0]) w[7:0]  = dd[7:0];
            ref_mem[int'(ra)] = w;
        end
        #1 st = stall;
        @(negedge clk);
        bus_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [19:0] a, input logic hit, input int len, output int n);
        logic [24:0] ra;
        logic [15:0] w;
        logic done;
        ra = {6'd0, a[19:1]};
        @(negedge clk);
        bus_read = 1'b1; bus_addr = a; region_hit = hit; region_addr = ra; region_writable = 1'b1;
        if (hit) begin
            w = ref_get(int'(ra));
            exp_rd.push_back(a[0] ? {8'h00, w[15:8]} : w);
            exp_txn.push_back('{wr: 1'b0, a: ra, d: 16'h0, s: 2'b00});
            issued++;
        end
        #1 n = stall ? 1 : 0;
        done = !stall;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (i + 1 >= len) bus_read = 1'b0;
            #1;
            if (!stall) done = 1'b1;
            else        n++;
        end
        bus_read = 1'b0;
        if (!done) chk("rd_timeout", 32'd1, 32'd0);
        if (hit && exp_rd.size() > 0) chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            #1;
            if (wbuf_level == 5'd0 && sdr_req == sdr_ack && !stall) done = 1'b1;
        end
        @(negedge clk);
        if (!done) chk(tag, 32'd1, 32'd0);
    endtask

    initial begin
        logic st;
        int   n, t0;
        logic done;

        ref_mem[32'h80] = 16'hBEEF;
        sdr_mem[32'h80] = 16'hBEEF;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(sdr_req), 32'd0);
        chk("rst_addr", 32'(sdr_addr), 32'd0);
        chk("rst_din", 32'(sdr_din), 32'd0);
        chk("rst_sel", 32'(sdr_wr_sel), 32'd0);
        chk("rst_level", 32'(wbuf_level), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // even read, ack three cycles after the request
        ack_delay = 3;
        t0 = toggles;
        bus_rd(20'h00100, 1'b1, 1, n);
        chk("t1_stall_cycles", 32'(n), 32'd5);
        chk("t1_toggles", 32'(toggles - t0), 32'd1);
        chk("t1_rd_data", 32'(rd_data), 32'hBEEF);

        // odd-byte write followed by a read of the same address
        ack_delay = 1;
        bus_wr(20'h00201, 2'b01, 16'h0055, 1'b1, 1'b1, st);
        chk("t2_wr_stall", 32'(st), 32'd0);
        bus_rd(20'h00201, 1'b1, 1, n);
        chk("t2_rd_data", 32'(rd_data), 32'h0055);
        wait_idle("t2_idle_timeout");

        // posted burst against a held-off SDRAM
        ack_hold = 1'b1;
        t0 = toggles;
        for (int i = 0; i < 4; i++) begin
            bus_wr(20'h01000 + 20'(2 * i), 2'b11, 16'h1000 + 16'(i), 1'b1, 1'b1, st);
            chk("t3_no_stall", 32'(st), 32'd0);
        end
        #1 chk("t3_level_after4", 32'(wbuf_level), 32'd3);
        bus_wr(20'h01008, 2'b11, 16'h1004, 1'b1, 1'b1, st);
        chk("t3_no_stall5", 32'(st), 32'd0);
        #1 chk("t3_level_after5", 32'(wbuf_level), 32'd4);
        bus_wr(20'h0100A, 2'b10, 16'h1505, 1'b1, 1'b1, st);
        chk("t3_full_stall", 32'(st), 32'd1);
        repeat (3) @(negedge clk);
        #1 chk("t3_skid_stall", 32'(stall), 32'd1);
        ack_hold = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            #1;
            if (!stall) done = 1'b1;
        end
        chk("t3_stall_release", 32'(done), 32'd1);
        chk("t3_level_at_release", 32'(wbuf_level), 32'd4);
        wait_idle("t3_idle_timeout");
        chk("t3_toggles", 32'(toggles - t0), 32'd6);

        // read queued behind three posted writes
        ack_delay = 2;
        t0 = toggles;
        for (int i = 0; i < 3; i++)
            bus_wr(20'h02000 + 20'(2 * i), 2'b11, 16'hA000 + 16'(i), 1'b1, 1'b1, st);
        bus_rd(20'h02002, 1'b1, 1, n);
        chk("t4_rd_data", 32'(rd_data), 32'hA001);
        chk("t4_toggles", 32'(toggles - t0), 32'd4);
        wait_idle("t4_idle_timeout");

        // dropped and ignored accesses, then a 2-cycle read strobe
        t0 = toggles;
        bus_wr(20'h03000, 2'b11, 16'h1234, 1'b1, 1'b0, st);
        chk("t5_nowr_stall", 32'(st), 32'd0);
        bus_rd(20'h03000, 1'b0, 1, n);
        chk("t5_miss_stall", 32'(n), 32'd0);
        repeat (4) @(negedge clk);
        chk("t5_no_toggles", 32'(toggles - t0), 32'd0);
        bus_rd(20'h00100, 1'b1, 2, n);
        chk("t5_two_cycle_toggles", 32'(toggles - t0), 32'd1);

        // asynchronous reset while a read is outstanding
        ack_delay = 6;
        @(negedge clk);
        bus_read = 1'b1; bus_addr = 20'h00100; region_hit = 1'b1; region_addr = 25'h80;
        exp_txn.push_back('{wr: 1'b0, a: 25'h80, d: 16'h0, s: 2'b00});
        issued++;
        @(negedge clk);
        bus_read = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_pre_stall", 32'(stall), 32'd1);
        chk("t6_pre_req", 32'(sdr_req), 32'(issued & 1));
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_stall", 32'(stall), 32'd0);
        chk("t6_rst_req", 32'(sdr_req), 32'd0);
        chk("t6_rst_level", 32'(wbuf_level), 32'd0);
        chk("t6_rst_rd_data", 32'(rd_data), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ack_delay = 1;
        bus_rd(20'h02004, 1'b1, 1, n);
        chk("t6_after_rd_data", 32'(rd_data), 32'hA002);
        wait_idle("t6_idle_timeout");

        chk("txn_left", 32'(exp_txn.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
